// File: rtl/ram_wr_arbiter.sv
// ram_wr_arbiter
// Shares one RAM write port between NREQ requesters using round-robin
// arbitration. An owner may keep the port for a burst of up to MAX_BURST
// beats. The write address, data and enable outputs are registered, so a
// beat accepted on gnt reaches the RAM one cycle later.

module ram_wr_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    gnt,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic [2:0]         owner
);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ptr;
    logic [2:0]  ptr_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [2:0]  owner_nxt;

    logic        win_found;
    logic [2:0]  win;
    logic [2:0]  cand;
    logic [2:0]  sel;
    logic        sel_req;
    logic        sel_last;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic        grant;

    // Index of the requester after i, wrapping NREQ-1 back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        if (int'(i) == NREQ - 1) begin
            return 3'd0;
        end
        return i + 3'd1;
    endfunction

    // Round-robin search: walk from ptr and take the first active request.
    always_comb begin
        win_found = 1'b0;
        win       = ptr;
        cand      = ptr;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (3'(i) == cand && req[i] && !win_found) begin
                    win_found = 1'b1;
                    win       = cand;
                end
            end
            cand = next_idx(cand);
        end
    end

    // Mux the request lines of the winner (IDLE) or the current owner (BURST).
    always_comb begin
        sel      = (state == IDLE) ? win : owner;
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == sel) begin
                sel_req  = req[i];
                sel_last = req_last[i];
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state logic: decide whether a beat is accepted and where the FSM goes.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        owner_nxt = owner;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant     = 1'b1;
                    owner_nxt = win;
                    if (sel_last || MAX_BURST == 1) begin
                        ptr_nxt = next_idx(win);
                    end else begin
                        state_nxt = BURST;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            BURST: begin
                if (sel_req) begin
                    grant = 1'b1;
                    if (sel_last || cnt == 4'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = next_idx(owner);
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_idx(owner);
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-hot grant to the selected requester, forced low while in reset.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = rst_n && grant && (3'(i) == sel);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
            owner <= 3'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
            busy  <= (state_nxt == BURST);
        end
    end

    // Registered RAM write port; address and data hold when no beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= grant;
            if (grant) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

endmodule
